rv32i_writeback_seq: RTL and testbench
======================================

# rv32i_writeback_seq

Registered, parametrised writeback stage for the rv32i pipeline. It sits after the memory stage and before the base register file. It resolves the destination value (ALU result, CSR read, or load data aligned and sign/zero-extended by `funct3`) and redirects the PC on trap entry or `mret`. Unlike the combinational stage it replaces, it waits on a load-data handshake with an optional timeout, holds a configurable flush window after a redirect, and keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32 — datapath width; only 32 or 64 are legal.
- `LOAD_TIMEOUT`, 16 — maximum cycles in `S_WAIT_LOAD`; 0 disables the timeout.
- `FLUSH_CYCLES`, 1 — cycles `o_flush` stays high after a redirect; must be ≥1.

Ports:
- `i_clk` in 1 — clock. The block has one clock. Reset is asynchronous and active-high.
- `i_rst` in 1 — asynchronous, active-high reset.
- `i_ce` in 1 — instruction valid / clock enable from the previous stage.
- `i_funct3` in 3; `i_opcode_load` in 1; `i_opcode_system` in 1 — decoded instruction fields.
- `i_wr_rd` in 1; `i_rd_addr` in 5; `i_rd` in XLEN — ALU result and its writeback request.
- `i_csr_out` in XLEN — CSR read value.
- `i_addr_lo` in 3 — low load-address bits; only [1:0] are used when XLEN=32.
- `i_load_ack` in 1; `i_load_data` in XLEN — raw load word and its valid strobe.
- `i_go_to_trap` in 1; `i_trap_address` in XLEN — trap entry and mtvec.
- `i_return_from_trap` in 1; `i_return_address` in XLEN — `mret` and mepc.
- `o_wr_rd` out 1; `o_rd_addr` out 5; `o_rd` out XLEN — register-file write port (registered).
- `o_next_pc` out XLEN; `o_change_pc` out 1 — PC redirect; `o_change_pc` is a one-cycle pulse.
- `o_stall` out 1 — combinational; holds the upstream stages.
- `o_flush` out 1 — flushes the upstream stages (registered).
- `o_retire` out 1 — one-cycle pulse per retired instruction.
- `o_instret` out 64 — retired-instruction count.
- `o_load_timeout` out 1 — one-cycle pulse when a load is abandoned.

## Operation
States: `S_RUN`, `S_WAIT_LOAD`, `S_REDIRECT`.

`S_RUN`, with `i_ce`=1, priority order:
1. **Trap entry** (`i_go_to_trap`):
   - Next cycle: `o_change_pc`=1, `o_next_pc`=`i_trap_address`, `o_flush`=1.
   - No write, no retire.
   - Go to `S_REDIRECT`.
2. **Trap return** (`i_return_from_trap`):
   - Same as trap entry, but `o_next_pc`=`i_return_address`.
   - `o_retire`=1, because `mret` retires.
3. **Load with `i_load_ack`=1**: register the aligned data, write, retire.
4. **Load with `i_load_ack`=0**:
   - Capture `rd_addr`, `wr_rd`, `funct3` and `addr_lo`.
   - Clear the timeout counter and go to `S_WAIT_LOAD`.
5. **CSR write** (`i_opcode_system` and `funct3`≠0): `o_rd`=`i_csr_out`.
6. **Otherwise**: `o_rd`=`i_rd`.

For cases 3, 5 and 6, the next cycle gives `o_wr_rd`=`wr_rd` and (`rd_addr`≠0), plus `o_retire`=1.

`S_WAIT_LOAD`:
- On `i_load_ack`: write the formatted captured load, retire, return to `S_RUN`.
- Otherwise the counter increments. If the counter equals `LOAD_TIMEOUT`-1 and `LOAD_TIMEOUT`≠0: pulse `o_load_timeout`, no write, no retire, return to `S_RUN`.
- `i_ce`, `i_go_to_trap` and `i_return_from_trap` are ignored here, because upstream is held.

`S_REDIRECT`:
- Counts `FLUSH_CYCLES` cycles with `o_flush`=1 and all `i_*` instruction inputs ignored.
- Then returns to `S_RUN`.

Load formatting:
- LB/LH sign-extend; LBU/LHU zero-extend.
- Lanes are selected by `addr_lo`.
- LW: sign-extends when XLEN=64, passes through when XLEN=32.
- LWU and LD are legal only when XLEN=64.
- Any other `funct3` passes the data through.

`o_stall` = (`S_WAIT_LOAD` and not `i_load_ack`) or `S_REDIRECT` or (`S_RUN` and `i_ce` and load and not `i_load_ack` and no trap/return).

`o_instret` increments by 1 on each `o_retire`, wrapping modulo 2^64.

## Timing
- Reset values: state=`S_RUN`; every output is 0, including `o_instret` and the counters. `o_stall` is 0 during reset.
- Latency: 1 cycle from an accepted instruction to `o_wr_rd`/`o_retire`.
- Load wait: ack at cycle N of the wait gives the write at N+1.
- Redirect: `o_change_pc` is high for exactly 1 cycle. `o_flush` is high for `FLUSH_CYCLES` cycles starting in the same cycle.
- When not writing, `o_wr_rd`/`o_retire`/`o_change_pc` return to 0; `o_rd`/`o_rd_addr` hold their last value.
- Simultaneous `i_go_to_trap` and `i_return_from_trap`: trap wins.
- Trap coincident with a load ack: trap wins and the load is discarded.
- Ack arriving in the timeout cycle: the ack wins.
- Asynchronous reset mid-wait or mid-redirect returns to `S_RUN` immediately with all outputs 0 and no retire.

## Structure
- Shared constants go in `rv32i_header.vh`: `funct3` load codes (LB, LH, LW, LD, LBU, LHU, LWU) and state encodings `S_RUN`/`S_WAIT_LOAD`/`S_REDIRECT`.
- One combinational sub-module, `rv32i_load_align` (`XLEN` parameter; inputs data, `funct3`, `addr_lo`; output aligned data), instantiated once on the mux of live and captured fields.

## Test plan
- ALU op, `i_rd`=0x1234, `rd_addr`=5, `i_wr_rd`=1 → next cycle `o_wr_rd`=1, `o_rd`=0x1234, `o_retire`=1, `o_instret`=1.
- LB, `addr_lo`=2, `i_load_data`=0x0080_0000, immediate ack → `o_rd`=0xFFFF_FF80. LHU, `addr_lo`=2, `i_load_data`=0x8001_0000 → `o_rd`=0x0000_8001.
- Load with ack after 3 cycles → `o_stall` high for 3 cycles, write on cycle 4. `LOAD_TIMEOUT`=4 with no ack → `o_load_timeout` pulse, no retire.
- `i_go_to_trap` and `i_return_from_trap` together, `i_trap_address`=0x100, `FLUSH_CYCLES`=3 → `o_next_pc`=0x100, `o_change_pc` for 1 cycle, `o_flush` for 3 cycles, no retire.
- `mret`, `i_return_address`=0x2000 → `o_next_pc`=0x2000, `o_retire`=1. `rd_addr`=0 write → `o_wr_rd`=0, retire counted.
- Preload `o_instret`=2^64−1 by forcing the counter register in the bench, retire once → `o_instret`=0. Assert `i_rst` during `S_WAIT_LOAD` → outputs 0, state `S_RUN`.

Source files
------------

// File: rtl/rv32i_writeback_seq_pkg.sv
// Shared types and constants for the rv32i writeback stage: FSM states and
// the funct3 load encodings.
package rv32i_writeback_seq_pkg;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_WAIT_LOAD = 2'd1,
    S_REDIRECT  = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/rv32i_writeback_seq_load_align.sv
// Combinational load formatter: selects the byte/half/word lane by the low
// address bits and sign- or zero-extends according to funct3.
module rv32i_load_align
  import rv32i_writeback_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] aligned
);

  logic [2:0]      lane;
  logic [XLEN-1:0] shifted;

  always_comb begin
    lane    = (XLEN == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
    shifted = data >> {lane, 3'b000};
    case (funct3)
      F3_LB:   aligned = XLEN'($signed(shifted[7:0]));
      F3_LH:   aligned = XLEN'($signed(shifted[15:0]));
      F3_LBU:  aligned = XLEN'(shifted[7:0]);
      F3_LHU:  aligned = XLEN'(shifted[15:0]);
      F3_LW:   aligned = (XLEN == 64) ? XLEN'($signed(shifted[31:0])) : data;
      F3_LWU:  aligned = (XLEN == 64) ? XLEN'(shifted[31:0]) : data;
      default: aligned = data;
    endcase
  end

endmodule

// File: rtl/rv32i_writeback_seq.sv
// Registered rv32i writeback stage: resolves the rd value, waits on load data
// with an optional timeout, redirects the PC on trap/mret and counts retires.
module rv32i_writeback_seq
  import rv32i_writeback_seq_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ce,
  input  logic [2:0]      i_funct3,
  input  logic            i_opcode_load,
  input  logic            i_opcode_system,
  input  logic            i_wr_rd,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_rd,
  input  logic [XLEN-1:0] i_csr_out,
  input  logic [2:0]      i_addr_lo,
  input  logic            i_load_ack,
  input  logic [XLEN-1:0] i_load_data,
  input  logic            i_go_to_trap,
  input  logic [XLEN-1:0] i_trap_address,
  input  logic            i_return_from_trap,
  input  logic [XLEN-1:0] i_return_address,
  output logic            o_wr_rd,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_change_pc,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_retire,
  output logic [63:0]     o_instret,
  output logic            o_load_timeout
);

  localparam int unsigned TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOAD_TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  wb_state_e       state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [4:0]      cap_rd_addr_q;
  logic            cap_wr_rd_q;
  logic [2:0]      cap_funct3_q, cap_addr_lo_q;
  logic [63:0]     instret_q;
  logic            capture, stall_c;
  logic            wr_rd_d, change_pc_d, flush_d, retire_d, timeout_d;
  logic [4:0]      rd_addr_d;
  logic [XLEN-1:0] rd_d, next_pc_d, aligned;
  logic [2:0]      al_funct3, al_addr_lo;

  // While waiting, the formatter must see the captured fields, not live ones.
  assign al_funct3  = (state_q == S_WAIT_LOAD) ? cap_funct3_q  : i_funct3;
  assign al_addr_lo = (state_q == S_WAIT_LOAD) ? cap_addr_lo_q : i_addr_lo;

  rv32i_load_align #(.XLEN(XLEN)) u_align (
    .data    (i_load_data),
    .funct3  (al_funct3),
    .addr_lo (al_addr_lo),
    .aligned (aligned)
  );

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    fcnt_d      = fcnt_q;
    capture     = 1'b0;
    stall_c     = 1'b0;
    wr_rd_d     = 1'b0;
    rd_addr_d   = o_rd_addr;
    rd_d        = o_rd;
    next_pc_d   = o_next_pc;
    change_pc_d = 1'b0;
    flush_d     = 1'b0;
    retire_d    = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (i_ce) begin
          if (i_go_to_trap || i_return_from_trap) begin
            next_pc_d   = i_go_to_trap ? i_trap_address : i_return_address;
            retire_d    = !i_go_to_trap;
            change_pc_d = 1'b1;
            flush_d     = 1'b1;
            fcnt_d      = '0;
            state_d     = S_REDIRECT;
          end else if (i_opcode_load && !i_load_ack) begin
            capture = 1'b1;
            stall_c = 1'b1;
            tmo_d   = '0;
            state_d = S_WAIT_LOAD;
          end else begin
            if (i_opcode_load)                        rd_d = aligned;
            else if (i_opcode_system && i_funct3 != 3'd0) rd_d = i_csr_out;
            else                                       rd_d = i_rd;
            wr_rd_d   = i_wr_rd && (i_rd_addr != 5'd0);
            rd_addr_d = i_rd_addr;
            retire_d  = 1'b1;
          end
        end
      end
      S_WAIT_LOAD: begin
        if (i_load_ack) begin
          rd_d      = aligned;
          wr_rd_d   = cap_wr_rd_q && (cap_rd_addr_q != 5'd0);
          rd_addr_d = cap_rd_addr_q;
          retire_d  = 1'b1;
          state_d   = S_RUN;
        end else begin
          stall_c = 1'b1;
          if (LOAD_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_RUN;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_REDIRECT: begin
        stall_c = 1'b1;
        if (fcnt_q == FLUSH_LAST) begin
          state_d = S_RUN;
        end else begin
          fcnt_d  = fcnt_q + 1'b1;
          flush_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign o_stall   = stall_c && !i_rst;
  assign o_instret = instret_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_RUN;
      tmo_q          <= '0;
      fcnt_q         <= '0;
      cap_rd_addr_q  <= '0;
      cap_wr_rd_q    <= 1'b0;
      cap_funct3_q   <= '0;
      cap_addr_lo_q  <= '0;
      instret_q      <= '0;
      o_wr_rd        <= 1'b0;
      o_rd_addr      <= '0;
      o_rd           <= '0;
      o_next_pc      <= '0;
      o_change_pc    <= 1'b0;
      o_flush        <= 1'b0;
      o_retire       <= 1'b0;
      o_load_timeout <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmo_q          <= tmo_d;
      fcnt_q         <= fcnt_d;
      if (capture) begin
        cap_rd_addr_q <= i_rd_addr;
        cap_wr_rd_q   <= i_wr_rd;
        cap_funct3_q  <= i_funct3;
        cap_addr_lo_q <= i_addr_lo;
      end
      instret_q      <= instret_q + 64'(retire_d);
      o_wr_rd        <= wr_rd_d;
      o_rd_addr      <= rd_addr_d;
      o_rd           <= rd_d;
      o_next_pc      <= next_pc_d;
      o_change_pc    <= change_pc_d;
      o_flush        <= flush_d;
      o_retire       <= retire_d;
      o_load_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rv32i_writeback_seq.sv
// Directed bench for rv32i_writeback_seq (XLEN=32, LOAD_TIMEOUT=4, FLUSH_CYCLES=3)
// with hand-computed expectations checked by immediate assertions.
module tb_rv32i_writeback_seq;
  import rv32i_writeback_seq_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ce, i_opcode_load, i_opcode_system, i_wr_rd;
  logic [2:0]  i_funct3, i_addr_lo;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_rd, i_csr_out, i_load_data, i_trap_address, i_return_address;
  logic        i_load_ack, i_go_to_trap, i_return_from_trap;
  logic        o_wr_rd, o_change_pc, o_stall, o_flush, o_retire, o_load_timeout;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd, o_next_pc;
  logic [63:0] o_instret;

  int n_assert = 0;
  int n_fail   = 0;

  rv32i_writeback_seq #(.XLEN(32), .LOAD_TIMEOUT(4), .FLUSH_CYCLES(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_funct3(i_funct3),
    .i_opcode_load(i_opcode_load), .i_opcode_system(i_opcode_system),
    .i_wr_rd(i_wr_rd), .i_rd_addr(i_rd_addr), .i_rd(i_rd), .i_csr_out(i_csr_out),
    .i_addr_lo(i_addr_lo), .i_load_ack(i_load_ack), .i_load_data(i_load_data),
    .i_go_to_trap(i_go_to_trap), .i_trap_address(i_trap_address),
    .i_return_from_trap(i_return_from_trap), .i_return_address(i_return_address),
    .o_wr_rd(o_wr_rd), .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_next_pc(o_next_pc),
    .o_change_pc(o_change_pc), .o_stall(o_stall), .o_flush(o_flush),
    .o_retire(o_retire), .o_instret(o_instret), .o_load_timeout(o_load_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_ce = 0; i_funct3 = 0; i_opcode_load = 0; i_opcode_system = 0;
    i_wr_rd = 0; i_rd_addr = 0; i_rd = 0; i_csr_out = 0; i_addr_lo = 0;
    i_load_ack = 0; i_load_data = 0; i_go_to_trap = 0; i_trap_address = 0;
    i_return_from_trap = 0; i_return_address = 0;
  endtask

  task automatic alu(input logic [4:0] rd_addr, input logic [31:0] val);
    idle();
    i_ce = 1; i_wr_rd = 1; i_rd_addr = rd_addr; i_rd = val;
  endtask

  task automatic load(input logic [2:0] f3, input logic [2:0] lo,
                      input logic [31:0] data, input logic ack, input logic [4:0] rd_addr);
    idle();
    i_ce = 1; i_opcode_load = 1; i_funct3 = f3; i_addr_lo = lo;
    i_load_data = data; i_load_ack = ack; i_wr_rd = 1; i_rd_addr = rd_addr;
  endtask

  initial begin
    idle();
    // Reset, with a would-stall load presented on the inputs
    i_rst = 1; i_ce = 1; i_opcode_load = 1;
    @(negedge i_clk); @(negedge i_clk);
    check("rst_stall", 64'(o_stall), 0);
    check("rst_wr", 64'(o_wr_rd), 0);
    check("rst_rd", 64'(o_rd), 0);
    check("rst_instret", o_instret, 0);
    check("rst_flush", 64'(o_flush), 0);
    idle();
    i_rst = 0;
    step();

    // ALU op
    alu(5'd5, 32'h1234);
    step(); idle();
    check("alu_wr", 64'(o_wr_rd), 1);
    check("alu_rd", 64'(o_rd), 64'h1234);
    check("alu_rd_addr", 64'(o_rd_addr), 5);
    check("alu_retire", 64'(o_retire), 1);
    check("alu_instret", o_instret, 1);
    step();
    check("idle_retire", 64'(o_retire), 0);
    check("idle_wr", 64'(o_wr_rd), 0);
    check("idle_rd_hold", 64'(o_rd), 64'h1234);

    // Loads with immediate ack
    load(F3_LB, 3'd2, 32'h0080_0000, 1'b1, 5'd7);
    #1 check("lb_stall", 64'(o_stall), 0);
    step(); idle();
    check("lb_rd", 64'(o_rd), 64'hFFFF_FF80);
    check("lb_instret", o_instret, 2);
    load(F3_LHU, 3'd2, 32'h8001_0000, 1'b1, 5'd7);
    step(); idle();
    check("lhu_rd", 64'(o_rd), 64'h0000_8001);
    load(F3_LH, 3'd0, 32'h0000_8001, 1'b1, 5'd8);
    step(); idle();
    check("lh_rd", 64'(o_rd), 64'hFFFF_8001);
    check("lh_instret", o_instret, 4);

    // CSR read
    alu(5'd3, 32'h1111);
    i_opcode_system = 1; i_funct3 = 3'd1; i_csr_out = 32'hCAFE;
    step(); idle();
    check("csr_rd", 64'(o_rd), 64'hCAFE);
    check("csr_instret", o_instret, 5);

    // Load acked on the fourth cycle; live funct3/addr_lo changed while waiting
    load(F3_LW, 3'd0, 32'h0, 1'b0, 5'd9);
    #1 check("wl_stall0", 64'(o_stall), 1);
    step(); idle();
    i_addr_lo = 3'd1; i_load_data = 32'hDEAD_BEEF;
    #1 check("wl_stall1", 64'(o_stall), 1);
    check("wl_nowr", 64'(o_wr_rd), 0);
    step();
    check("wl_stall2", 64'(o_stall), 1);
    step();
    i_load_ack = 1;
    #1 check("wl_ack_stall", 64'(o_stall), 0);
    step(); idle();
    check("wl_rd", 64'(o_rd), 64'hDEAD_BEEF);
    check("wl_rd_addr", 64'(o_rd_addr), 9);
    check("wl_wr", 64'(o_wr_rd), 1);
    check("wl_instret", o_instret, 6);

    // Load timeout after 4 wait cycles
    load(F3_LW, 3'd0, 32'h0, 1'b0, 5'd10);
    step(); idle();
    step(); step(); step();
    check("to_early", 64'(o_load_timeout), 0);
    check("to_stall", 64'(o_stall), 1);
    step();
    check("to_pulse", 64'(o_load_timeout), 1);
    check("to_noretire", 64'(o_retire), 0);
    check("to_nowr", 64'(o_wr_rd), 0);
    check("to_instret", o_instret, 6);
    check("to_run_stall", 64'(o_stall), 0);
    step();
    check("to_pulse_end", 64'(o_load_timeout), 0);

    // Trap + mret together, coincident with an acked load: trap wins
    load(F3_LW, 3'd0, 32'h55, 1'b1, 5'd11);
    i_go_to_trap = 1; i_return_from_trap = 1;
    i_trap_address = 32'h100; i_return_address = 32'h2000;
    #1 check("trap_stall", 64'(o_stall), 0);
    step();
    alu(5'd12, 32'h9999);
    check("trap_pc", 64'(o_next_pc), 64'h100);
    check("trap_change", 64'(o_change_pc), 1);
    check("trap_flush1", 64'(o_flush), 1);
    check("trap_noretire", 64'(o_retire), 0);
    check("trap_nowr", 64'(o_wr_rd), 0);
    check("trap_redir_stall", 64'(o_stall), 1);
    step();
    check("trap_change_end", 64'(o_change_pc), 0);
    check("trap_flush2", 64'(o_flush), 1);
    step();
    check("trap_flush3", 64'(o_flush), 1);
    step(); idle();
    check("trap_flush_end", 64'(o_flush), 0);
    check("trap_ignored_wr", 64'(o_wr_rd), 0);
    check("trap_rd_hold", 64'(o_rd), 64'hDEAD_BEEF);
    check("trap_rd_addr_hold", 64'(o_rd_addr), 9);
    check("trap_instret", o_instret, 6);

    // mret retires
    idle(); i_ce = 1; i_return_from_trap = 1; i_return_address = 32'h2000;
    step(); idle();
    check("mret_pc", 64'(o_next_pc), 64'h2000);
    check("mret_change", 64'(o_change_pc), 1);
    check("mret_retire", 64'(o_retire), 1);
    check("mret_instret", o_instret, 7);
    step(); step(); step();
    check("mret_flush_end", 64'(o_flush), 0);

    // Write to x0 is suppressed but still retires
    alu(5'd0, 32'h77);
    step(); idle();
    check("x0_wr", 64'(o_wr_rd), 0);
    check("x0_retire", 64'(o_retire), 1);
    check("x0_instret", o_instret, 8);

    // instret wraps
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    #1 check("wrap_pre", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    alu(5'd1, 32'h1);
    step(); idle();
    check("wrap_post", o_instret, 0);
    check("wrap_retire", 64'(o_retire), 1);

    // Asynchronous reset in the middle of a load wait
    load(F3_LW, 3'd0, 32'h0, 1'b0, 5'd13);
    step(); idle();
    #2 i_rst = 1;
    #1;
    check("arst_state", 64'(dut.state_q), 64'(S_RUN));
    check("arst_stall", 64'(o_stall), 0);
    check("arst_wr", 64'(o_wr_rd), 0);
    check("arst_rd", 64'(o_rd), 0);
    check("arst_rd_addr", 64'(o_rd_addr), 0);
    check("arst_pc", 64'(o_next_pc), 0);
    check("arst_instret", o_instret, 0);
    @(negedge i_clk);
    i_rst = 0;
    step();
    check("arst_noretire", 64'(o_retire), 0);
    check("arst_run", 64'(dut.state_q), 64'(S_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
